// File: rtl/fetch_seq.sv
// fetch_seq: program-counter sequencer with BNE / JR-target handling.
// Optional executed-cycle counter enabled by FETCH_SEQ_CYCLE_CNT_EN.
module fetch_seq #(
  parameter int PC_W = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_target,
  input  logic            Halt,
  output logic [PC_W-1:0] pc,
  output logic            read_jump,
  output logic            running,
  output logic            Done,
  output logic [15:0]     cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    JWAIT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pc_nx;
  logic            start_ok;

  // JWAIT always takes jump_target; a missing jump_en is treated as set,
  // so the input carries no extra information here.
  logic unused_jump_en;
  assign unused_jump_en = jump_en;

  assign start_ok = Start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // PC register
  always_ff @(posedge Clk) begin
    if (Reset) pc <= '0;
    else       pc <= pc_nx;
  end

  // Next state and next pc
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nx = RUN;
          pc_nx    = start_addr;
        end
      end
      RUN: begin
        if (Halt) begin
          state_nx = DONE;
        end else if (is_branch && branch_taken) begin
          state_nx = JWAIT;
          pc_nx    = pc + PC_W'(1);
        end else if (is_branch) begin
          pc_nx    = pc + PC_W'(2);
        end else begin
          pc_nx    = pc + PC_W'(1);
        end
      end
      JWAIT: begin
        state_nx = RUN;
        pc_nx    = jump_target;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    read_jump = 1'b0;
    running   = 1'b0;
    Done      = 1'b0;
    unique case (state)
      IDLE:  ;
      RUN:   running = 1'b1;
      JWAIT: begin
        running   = 1'b1;
        read_jump = 1'b1;
      end
      DONE:  Done = 1'b1;
      default: ;
    endcase
  end

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt;

  // Saturating count of cycles spent executing
  always_ff @(posedge Clk) begin
    if (Reset)
      cnt <= '0;
    else if (start_ok)
      cnt <= '0;
    else if (running && (cnt != 16'hFFFF))
      cnt <= cnt + 16'd1;
  end

  assign cycle_count = cnt;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign cycle_count = '0;
`endif

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter PC_W, default 10: program counter width in bits; instruction memory depth is 2^PC_W words.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset; takes effect on the Clk rising edge, overrides all other inputs.
REQ-004 Start  input  1  begin program execution; sampled only in IDLE and DONE.
REQ-005 start_addr  input  PC_W  first instruction address, captured when Start is accepted.
REQ-006 is_branch  input  1  current instruction is BNE (opcode 3'b111).
REQ-007 branch_taken  input  1  BNE operands unequal; meaningful only with is_branch=1.
REQ-008 jump_en  input  1  decoder indicates the current word is a JR target word.
REQ-009 jump_target  input  PC_W  absolute target from the jump LUT, indexed by the current word's low 6 bits.
REQ-010 Halt  input  1  decoder halt indication for the current instruction.
REQ-011 pc  output  PC_W  instruction fetch address.
REQ-012 read_jump  output  1  tells the decoder to treat the current word as a JR target word.
REQ-013 running  output  1  high in RUN and JWAIT.
REQ-014 Done  output  1  high in DONE.
REQ-015 cycle_count  output  16  executed-cycle count (see Configuration).

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, JWAIT, DONE; outputs read_jump, running and Done SHALL be Moore outputs decoded from state only.
REQ-017 In IDLE, Start=1 SHALL load pc<=start_addr and move to RUN; otherwise pc SHALL hold.
REQ-018 In RUN with Halt=1, the FSM SHALL move to DONE and pc SHALL hold; Halt has priority over all branch inputs.
REQ-019 In RUN, for is_branch=1 and branch_taken=1, the FSM SHALL set pc<=pc+1 and move to JWAIT.
REQ-020 In RUN, for is_branch=1 and branch_taken=0, the FSM SHALL set pc<=pc+2 to skip the target word, and stay in RUN.
REQ-021 In RUN with neither branch nor halt, the FSM SHALL set pc<=pc+1.
REQ-022 In JWAIT, read_jump SHALL be 1 for exactly that one cycle.
REQ-023 In JWAIT, the FSM SHALL set pc<=jump_target and return to RUN; Halt is ignored in JWAIT.
REQ-024 In JWAIT, if jump_en=0 (protocol error), the FSM SHALL treat the cycle as jump_en=1.
REQ-025 All pc arithmetic SHALL wrap modulo 2^PC_W; pc+2 from 2^PC_W-1 yields 1.
REQ-026 In DONE, pc SHALL hold; Start=1 SHALL reload pc<=start_addr and move to RUN.
REQ-027 Start SHALL be ignored in RUN and JWAIT; is_branch, branch_taken and jump_en SHALL be ignored in IDLE and DONE.

Reset
REQ-028 On Reset=1, the block SHALL enter IDLE with pc=0, read_jump=0, running=0, Done=0 and cycle_count=0 after the edge.
REQ-029 A Reset asserted in any state, including JWAIT, SHALL abort the program with no pending jump retained.
REQ-030 Reset and Start asserted together SHALL yield IDLE.

Configuration
REQ-031 With macro FETCH_SEQ_CYCLE_CNT_EN defined, cycle_count SHALL behave as follows:
- cleared to 0 when Start is accepted;
- incremented once per cycle spent in RUN or JWAIT;
- saturates at 16'hFFFF;
- holds in DONE and IDLE.
REQ-032 With FETCH_SEQ_CYCLE_CNT_EN undefined, cycle_count SHALL be constant 0 and no counter register is built.

Verification
REQ-033 Reset, then Start with start_addr=10'h020 -> next cycle running=1 and pc=0x020; three plain cycles -> pc=0x023.
REQ-034 At pc=0x040, is_branch=1, branch_taken=1 -> pc=0x041 with read_jump=1; jump_target=0x1A0 -> next cycle pc=0x1A0, read_jump=0.
REQ-035 At pc=0x040, is_branch=1, branch_taken=0 -> pc=0x042, read_jump stays 0.
REQ-036 Halt=1 at pc=0x055 -> Done=1, running=0, pc holds 0x055; Start with start_addr=0 -> pc=0, running=1, cycle_count=0 (with macro).
REQ-037 Reset=1 during JWAIT at pc=0x3FF -> IDLE with pc=0; separately, a not-taken BNE at pc=0x3FF -> pc=0x001.
REQ-038 With macro defined, 70000 RUN cycles -> cycle_count=16'hFFFF; with macro undefined -> cycle_count=0 throughout.
